// File: rtl/bus_cycle_initiator.sv
// ---------------------------------------------------------------------------
// bus_cycle_initiator
//
// 68000-style asynchronous bus master. Accepts one single-word command at a
// time and runs it as an AS/UDS/LDS/RW bus cycle that DTACK terminates.
// It lets the CPLD drive the DRAM controller's CPU-side port with no CPU
// present (memory test, fills, bring-up).
//
// Optional feature: define BUS_TIMEOUT_EN to add a STROBE-phase watchdog.
// The watchdog ends a cycle with RSP_BERR=1 after TIMEOUT_CYCLES strobe
// cycles. TIMEOUT_CYCLES (2..255, default 64) is used only in that build.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   CMD_VALID/READY   command handshake (READY is high only in IDLE)
//   CMD_WRITE         1 = write, 0 = read
//   CMD_ADDR[23:0]    byte address (bit 0 ignored)
//   CMD_BE[1:0]       byte enables [1]=upper [0]=lower, 2'b00 means both
//   CMD_WDATA[15:0]   write data
//   RSP_VALID         one-cycle completion pulse
//   RSP_RDATA[15:0]   read data, held until the next response
//   RSP_BERR          bus-error (timeout) flag, valid with RSP_VALID
//   ADDR_OUT[23:0]    bus address, bit 0 driven 0
//   AS, UDS, LDS      active-low address / data strobes
//   RW                1 = read
//   DATA_OUT[15:0]    write data, DATA_OE enables the bus drivers
//   DATA_IN[15:0]     read data
//   DTACK             asynchronous active-low acknowledge
// ---------------------------------------------------------------------------
module bus_cycle_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [23:0] CMD_ADDR,
    input  logic [1:0]  CMD_BE,
    input  logic [15:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_BERR,
    output logic [23:0] ADDR_OUT,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DTACK
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_RECOVER
    } state_t;

    state_t      state, state_n;
    logic        dtack_meta, dtack_s;
    logic [1:0]  be_q, be_n;

    logic        cmd_ready_n, rsp_valid_n;
    logic [15:0] rsp_rdata_n;
    logic [23:0] addr_n;
    logic        as_n, uds_n, lds_n, rw_n, data_oe_n;
    logic [15:0] data_out_n;
    logic        strobe_end, timed_out;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  to_cnt, to_cnt_n;
    logic        rsp_berr_n;
`else
    assign RSP_BERR = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_n     = state;
        be_n        = be_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = RSP_RDATA;
        addr_n      = ADDR_OUT;
        as_n        = AS;
        uds_n       = UDS;
        lds_n       = LDS;
        rw_n        = RW;
        data_out_n  = DATA_OUT;
        data_oe_n   = DATA_OE;
        timed_out   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        rsp_berr_n  = RSP_BERR;
        to_cnt_n    = to_cnt;
        // DTACK takes priority when both arrive on the same edge.
        if (state == ST_STROBE && dtack_s && to_cnt == TIMEOUT_LAST)
            timed_out = 1'b1;
`endif
        strobe_end = (state == ST_STROBE) && (!dtack_s || timed_out);

        case (state)
            ST_IDLE: begin
`ifdef BUS_TIMEOUT_EN
                to_cnt_n = 8'd0;
`endif
                if (CMD_VALID) begin
                    addr_n = {CMD_ADDR[23:1], 1'b0};
                    rw_n   = ~CMD_WRITE;
                    be_n   = (CMD_BE == 2'b00) ? 2'b11 : CMD_BE;
                    if (CMD_WRITE) begin
                        data_out_n = CMD_WDATA;
                        data_oe_n  = 1'b1;
                    end
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                as_n    = 1'b0;
                uds_n   = ~be_q[1];
                lds_n   = ~be_q[0];
                state_n = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_end) begin
                    if (timed_out)
                        rsp_rdata_n = 16'h0000;
                    else if (RW)
                        rsp_rdata_n = DATA_IN;
`ifdef BUS_TIMEOUT_EN
                    rsp_berr_n = timed_out;
`endif
                    rsp_valid_n = 1'b1;
                    as_n        = 1'b1;
                    uds_n       = 1'b1;
                    lds_n       = 1'b1;
                    rw_n        = 1'b1;
                    data_oe_n   = 1'b0;
                    state_n     = ST_RECOVER;
                end
`ifdef BUS_TIMEOUT_EN
                else begin
                    to_cnt_n = to_cnt + 8'd1;
                end
`endif
            end
            ST_RECOVER: begin
                // Wait for the target to release DTACK before the next cycle.
                if (dtack_s)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Registered, so a command arriving on the IDLE entry edge waits one.
        cmd_ready_n = (state_n == ST_IDLE);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            dtack_meta <= 1'b1;
            dtack_s    <= 1'b1;
            be_q       <= 2'b11;
            CMD_READY  <= 1'b1;
            RSP_VALID  <= 1'b0;
            RSP_RDATA  <= 16'h0000;
            ADDR_OUT   <= 24'h000000;
            AS         <= 1'b1;
            UDS        <= 1'b1;
            LDS        <= 1'b1;
            RW         <= 1'b1;
            DATA_OUT   <= 16'h0000;
            DATA_OE    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            RSP_BERR   <= 1'b0;
            to_cnt     <= 8'd0;
`endif
        end else begin
            // Two-flop synchronizer for the asynchronous DTACK.
            dtack_meta <= DTACK;
            dtack_s    <= dtack_meta;
            state      <= state_n;
            be_q       <= be_n;
            CMD_READY  <= cmd_ready_n;
            RSP_VALID  <= rsp_valid_n;
            RSP_RDATA  <= rsp_rdata_n;
            ADDR_OUT   <= addr_n;
            AS         <= as_n;
            UDS        <= uds_n;
            LDS        <= lds_n;
            RW         <= rw_n;
            DATA_OUT   <= data_out_n;
            DATA_OE    <= data_oe_n;
`ifdef BUS_TIMEOUT_EN
            RSP_BERR   <= rsp_berr_n;
            to_cnt     <= to_cnt_n;
`endif
        end
    end

endmodule
